// File: rtl/string_stream_pkg.sv
// Shared types and prefix characters for the number-to-text stream stages.
// The upstream itoa/hextoa/octtoa/bintoa stage imports this package as well.
package string_stream_pkg;

    typedef enum logic [1:0] {
        INT = 2'd0,
        HEX = 2'd1,
        OCT = 2'd2,
        BIN = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        BODY   = 2'd2,
        TERM   = 2'd3
    } state_e;

    localparam logic [7:0] PREFIX_ZERO = 8'h30;
    localparam logic [7:0] PREFIX_HEX  = 8'h78;
    localparam logic [7:0] PREFIX_OCT  = 8'h6F;
    localparam logic [7:0] PREFIX_BIN  = 8'h62;

    // Radix letter that follows the leading '0' of the prefix.
    function automatic logic [7:0] prefix_char(kind_e kind);
        case (kind)
            HEX:     return PREFIX_HEX;
            OCT:     return PREFIX_OCT;
            BIN:     return PREFIX_BIN;
            default: return PREFIX_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/string_byte_streamer.sv
// Serialises one converted number string per transfer into an ASCII byte
// stream: radix prefix, body (clipped to MAX_LEN), then a terminator byte.
module string_byte_streamer
    import string_stream_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 64,
    parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  string       in_str,
    input  kind_e       in_kind,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        trunc,
    output logic [15:0] str_count
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    kind_e            kind_q, kind_d;
    string            str_q, str_d;
    logic             accept;
    logic             take;
    logic             in_over;

    logic             out_valid_d;
    logic             out_last_d;
    logic [7:0]       out_byte_d;

    assign accept = (state_q == IDLE) && in_valid;
    assign take   = out_valid && out_ready;

    // State register plus the latched string context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            kind_q  <= INT;
            str_q   <= "";
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            kind_q  <= kind_d;
            str_q   <= str_d;
        end
    end

    // Next-state logic; idx counts prefix bytes in PREFIX and body bytes in BODY.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        kind_d  = kind_q;
        str_d   = str_q;
        in_over = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    in_over = (in_str.len() > int'(MAX_LEN));
                    str_d   = in_str;
                    kind_d  = in_kind;
                    idx_d   = '0;
                    len_d   = in_over ? IDX_W'(MAX_LEN) : IDX_W'(in_str.len());
                    if (in_kind != INT) begin
                        state_d = PREFIX;
                    end else if (in_str.len() == 0) begin
                        state_d = TERM;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            PREFIX: begin
                if (take) begin
                    if (idx_q == IDX_W'(1)) begin
                        idx_d   = '0;
                        state_d = (len_q == '0) ? TERM : BODY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            BODY: begin
                if (take) begin
                    if (idx_q == len_q - IDX_W'(1)) begin
                        idx_d   = '0;
                        state_d = TERM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            TERM: begin
                if (take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the upcoming state, registered below so they hold
    // stable across back-pressure and appear the cycle after a transfer.
    always_comb begin
        out_valid_d = (state_d != IDLE);
        out_last_d  = (state_d == TERM);
        out_byte_d  = 8'h00;
        unique case (state_d)
            PREFIX:  out_byte_d = (idx_d == '0) ? PREFIX_ZERO : prefix_char(kind_d);
            BODY:    out_byte_d = 8'(str_d.getc(int'(idx_d)));
            TERM:    out_byte_d = TERM_CHAR;
            default: out_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= 8'h00;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_byte  <= out_byte_d;
        end
    end

    // Truncation flag is per string; completed-string counter wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trunc     <= 1'b0;
            str_count <= 16'h0000;
        end else begin
            if (accept) begin
                trunc <= in_over;
            end
            if ((state_q == TERM) && take) begin
                str_count <= str_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_string_byte_streamer.sv
// Randomised, self-checking bench for string_byte_streamer against a
// string-level model of prefix + clipped body + terminator.
module tb_string_byte_streamer;
    import string_stream_pkg::*;

    localparam int unsigned ML = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    string       in_str;
    kind_e       in_kind;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        trunc;
    logic [15:0] str_count;

    int    checks = 0;
    int    errors = 0;

    string got_s;
    string exp_s;
    int    last_cnt, last_pos, viol, bubbles, busy_rdy, n_cyc;
    bit    tmo;
    int    exp_count;
    bit    exp_trunc;

    always #5 clk = ~clk;

    string_byte_streamer #(.MAX_LEN(ML), .TERM_CHAR(8'h0A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_str    (in_str),
        .in_kind   (in_kind),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .trunc     (trunc),
        .str_count (str_count)
    );

    function automatic string model(string s, kind_e k);
        string r;
        int    n;
        case (k)
            HEX:     r = "0x";
            OCT:     r = "0o";
            BIN:     r = "0b";
            default: r = "";
        endcase
        n = (s.len() > int'(ML)) ? int'(ML) : s.len();
        if (n > 0) r = {r, s.substr(0, n - 1)};
        r = {r, "\n"};
        return r;
    endfunction

    function automatic string hexs(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h ", r, s.getc(i));
        return r;
    endfunction

    // Offers one string, then drains the output with the chosen ready
    // pattern (0 always, 1 every other cycle, 2 random). Ends on the
    // negedge after the terminator handshake.
    task automatic drive_string(input string s, input kind_e k, input int mode);
        int         cyc;
        bit         done, stalled, rdy;
        logic [7:0] held_b;
        logic       held_l;
        got_s = ""; last_cnt = 0; last_pos = -1; viol = 0; bubbles = 0;
        busy_rdy = 0; n_cyc = 0; tmo = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b1;
        in_str   = s;
        in_kind  = k;
        @(negedge clk);
        // Junk offered while busy must be ignored.
        in_str  = "JUNK";
        in_kind = HEX;
        done = 1'b0; stalled = 1'b0; held_b = 8'h00; held_l = 1'b0;
        while (!done && n_cyc < 300) begin
            if (in_ready) busy_rdy++;
            if (!out_valid) begin
                bubbles++;
                out_ready = 1'b0;
            end else begin
                if (stalled && (out_byte !== held_b || out_last !== held_l)) viol++;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (n_cyc % 2 == 1);
                    default: rdy = ($urandom_range(0, 1) == 1);
                endcase
                out_ready = rdy;
                if (rdy) begin
                    if (out_last) begin
                        last_cnt++;
                        last_pos = got_s.len();
                        done = 1'b1;
                    end
                    got_s   = $sformatf("%s%c", got_s, out_byte);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_b  = out_byte;
                    held_l  = out_last;
                end
            end
            @(negedge clk);
            n_cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tmo       = !done;
        exp_s     = model(s, k);
        if (done) exp_count = (exp_count + 1) & 16'hFFFF;
        exp_trunc = (s.len() > int'(ML));
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got %h want 00", out_byte); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL reset_trunc got %b want 0", trunc); end
        checks++; if (str_count !== 16'h0000) begin errors++; $display("FAIL reset_str_count got %h want 0000", str_count); end
    endtask

    task automatic test_hex_ff();
        drive_string("ff", HEX, 0);
        checks++; if (got_s != exp_s) begin errors++; $display("FAIL hex_ff_bytes got %s want %s", hexs(got_s), hexs(exp_s)); end
        checks++; if (last_cnt !== 1 || last_pos !== 4) begin errors++; $display("FAIL hex_ff_last got cnt %0d pos %0d want 1/4", last_cnt, last_pos); end
        checks++; if (n_cyc !== 5 || bubbles !== 0) begin errors++; $display("FAIL hex_ff_cycles got %0d/%0d want 5/0", n_cyc, bubbles); end
        checks++; if (str_count !== 16'd1) begin errors++; $display("FAIL hex_ff_count got %0d want 1", str_count); end
    endtask

    task automatic test_int_neg();
        drive_string("-12", INT, 0);
        checks++; if (got_s != exp_s) begin errors++; $display("FAIL int_neg_bytes got %s want %s", hexs(got_s), hexs(exp_s)); end
        checks++; if (n_cyc !== 4 || bubbles !== 0) begin errors++; $display("FAIL int_neg_cycles got %0d/%0d want 4/0", n_cyc, bubbles); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL int_neg_idle got rdy %b vld %b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_bin_toggle();
        drive_string("101", BIN, 1);
        checks++; if (got_s != exp_s) begin errors++; $display("FAIL bin_toggle_bytes got %s want %s", hexs(got_s), hexs(exp_s)); end
        checks++; if (viol !== 0 || bubbles !== 0) begin errors++; $display("FAIL bin_toggle_hold got viol %0d bubbles %0d want 0/0", viol, bubbles); end
        checks++; if (last_pos !== 5) begin errors++; $display("FAIL bin_toggle_last got %0d want 5", last_pos); end
    endtask

    task automatic test_empty();
        drive_string("", INT, 0);
        checks++; if (got_s != exp_s || last_pos !== 0) begin errors++; $display("FAIL empty_int got %s pos %0d want %s pos 0", hexs(got_s), last_pos, hexs(exp_s)); end
        drive_string("", OCT, 0);
        checks++; if (got_s != exp_s || last_pos !== 2) begin errors++; $display("FAIL empty_oct got %s pos %0d want %s pos 2", hexs(got_s), last_pos, hexs(exp_s)); end
    endtask

    task automatic test_trunc();
        drive_string("123456", HEX, 0);
        checks++; if (got_s != exp_s) begin errors++; $display("FAIL trunc_bytes got %s want %s", hexs(got_s), hexs(exp_s)); end
        checks++; if (trunc !== 1'b1) begin errors++; $display("FAIL trunc_set got %b want 1", trunc); end
        repeat (3) @(negedge clk);
        checks++; if (trunc !== 1'b1) begin errors++; $display("FAIL trunc_sticky got %b want 1", trunc); end
        drive_string("abcd", HEX, 0);
        checks++; if (got_s != exp_s || got_s.len() != 2 + int'(ML) + 1) begin errors++; $display("FAIL max_len_bytes got %s want %s", hexs(got_s), hexs(exp_s)); end
        checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL trunc_clear got %b want 0", trunc); end
    endtask

    task automatic test_back_to_back();
        string s[4] = '{"9", "ab", "xyz", "Q"};
        kind_e k[4] = '{INT, HEX, OCT, BIN};
        for (int i = 0; i < 4; i++) begin
            drive_string(s[i], k[i], 0);
            checks++; if (got_s != exp_s || busy_rdy !== 0) begin errors++; $display("FAIL b2b_%0d got %s busy_rdy %0d want %s 0", i, hexs(got_s), busy_rdy, hexs(exp_s)); end
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d got rdy %b vld %b want 1/0", i, in_ready, out_valid); end
        end
        checks++; if (str_count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count got %0d want %0d", str_count, exp_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            string s = "";
            int    n = $urandom_range(0, 7);
            kind_e k = kind_e'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) s = $sformatf("%s%c", s, 8'($urandom_range(33, 126)));
            drive_string(s, k, 2);
            checks++;
            if (tmo || got_s != exp_s || last_cnt !== 1 || last_pos !== exp_s.len() - 1 || viol !== 0 || bubbles !== 0) begin
                errors++;
                $display("FAIL rand_%0d got %s last %0d@%0d viol %0d bub %0d want %s", i, hexs(got_s), last_cnt, last_pos, viol, bubbles, hexs(exp_s));
            end
            checks++;
            if (str_count !== 16'(exp_count) || trunc !== exp_trunc) begin
                errors++;
                $display("FAIL rand_state_%0d got cnt %0d trunc %b want %0d %b", i, str_count, trunc, exp_count, exp_trunc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b1; in_str = "abcd"; in_kind = INT;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_byte !== 8'h63 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_progress got %h vld %b want 63 1", out_byte, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_last !== 1'b0) begin errors++; $display("FAIL mid_reset_out got vld %b byte %h last %b want 0 00 0", out_valid, out_byte, out_last); end
        checks++; if (str_count !== 16'h0000 || trunc !== 1'b0) begin errors++; $display("FAIL mid_reset_state got cnt %0d trunc %b want 0 0", str_count, trunc); end
        out_ready = 1'b0;
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got rdy %b vld %b want 1 0", in_ready, out_valid); end
        drive_string("7", INT, 0);
        checks++; if (got_s != exp_s) begin errors++; $display("FAIL mid_next_bytes got %s want %s", hexs(got_s), hexs(exp_s)); end
        checks++; if (str_count !== 16'd1) begin errors++; $display("FAIL mid_next_count got %0d want 1", str_count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_str    = "";
        in_kind   = INT;
        exp_count = 0;
        exp_trunc = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_hex_ff();
        test_int_neg();
        test_bin_toggle();
        test_empty();
        test_trunc();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/string_byte_streamer.md
STRING_BYTE_STREAMER -- requirements
Module: string_byte_streamer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64: maximum body characters emitted per string.
REQ-002 SHALL have parameter TERM_CHAR, default 8'h0A: terminator byte appended to every string.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: upstream offers a string.
REQ-006 SHALL have port in_ready, output, 1: block accepts a string this cycle.
REQ-007 SHALL have port in_str, input, string: text from the upstream itoa/hextoa/octtoa/bintoa stage.
REQ-008 SHALL have port in_kind, input, 2 (kind_e): 0 INT, 1 HEX, 2 OCT, 3 BIN.
REQ-009 SHALL have port out_valid, output, 1: out_byte is valid.
REQ-010 SHALL have port out_ready, input, 1: downstream takes the byte.
REQ-011 SHALL have port out_byte, output, 8: current ASCII character.
REQ-012 SHALL have port out_last, output, 1: high with the terminator byte only.
REQ-013 SHALL have port trunc, output, 1: sticky per string; body exceeded MAX_LEN.
REQ-014 SHALL have port str_count, output, 16: completed strings, wraps 16'hFFFF to 0.

Function
REQ-015 SHALL use FSM states IDLE, PREFIX, BODY, TERM.
REQ-016 SHALL drive in_ready=1 only in IDLE; a transfer occurs when in_valid and in_ready are both high.
REQ-017 SHALL, on a transfer, latch in_str and in_kind, clear trunc, and set trunc=1 if in_str.len() > MAX_LEN.
REQ-018 SHALL, on a transfer, go to PREFIX for HEX/OCT/BIN, to BODY for INT with non-zero length, and to TERM for INT with empty string; first out_valid is the cycle after the transfer.
REQ-019 SHALL emit prefix "0x", "0o", or "0b" (2 bytes), then go to BODY, or to TERM if the string is empty.
REQ-020 SHALL emit body bytes getc(0)..getc(min(len,MAX_LEN)-1) in order, then go to TERM.
REQ-021 SHALL emit TERM_CHAR with out_last=1 in TERM; on that handshake SHALL increment str_count and return to IDLE.
REQ-022 SHALL advance one byte per out_valid&&out_ready cycle; out_byte/out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 SHALL keep out_valid high continuously from the first byte to the terminator handshake, with no bubbles while out_ready=1.
REQ-024 SHALL hold in_ready=0 from a transfer until the cycle after the terminator handshake; back-to-back strings SHALL incur exactly one IDLE cycle.
REQ-025 SHALL ignore in_str, in_kind, and in_valid changes outside IDLE.
REQ-026 SHALL, for a maximal string, emit exactly 2+MAX_LEN+1 bytes.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, out_valid=0, out_last=0, out_byte=0, trunc=0, str_count=0, and the latched string to "".
REQ-028 SHALL, on reset mid-string, discard the string without emitting a terminator; in_ready=1 on the first clock after rst_n rises.

Structure
REQ-029 SHALL place kind_e, state_e, and the prefix-character constants in shared package string_stream_pkg, also imported by the upstream conversion stage.
REQ-030 SHALL be a single module with no sub-modules; the byte index counter SHALL be $clog2(MAX_LEN+1) bits.

Verification
REQ-031 HEX "ff", out_ready=1 -> bytes 30,78,66,66,0A; out_last only on 0A; str_count=1.
REQ-032 INT "-12" -> bytes 2D,31,32,0A with no prefix; 4 consecutive valid cycles.
REQ-033 BIN "101", out_ready toggling every other cycle -> bytes 30,62,31,30,31,0A each held stable until taken.
REQ-034 INT "" -> single byte 0A with out_last=1; OCT "" -> 30,6F,0A.
REQ-035 MAX_LEN=4, HEX "123456" -> 30,78,31,32,33,34,0A; trunc=1 until next accept.
REQ-036 rst_n pulsed low after 2nd body byte of "abcd" -> out_valid=0 immediately; next string "7" INT -> 37,0A; str_count=1.
